// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP-RISC execute-stage shift unit:
// shift opcodes, FSM state encoding and default datapath sizes.
package kgp_risc_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_PASS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // An operation skips the SHIFT state when there is nothing to shift
  // or the opcode is the reserved pass-through encoding.
  function automatic logic needs_shift(input logic [1:0] op, input logic shamt_zero);
    return (op != SH_PASS) && !shamt_zero;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift: one iteration of the sequential shifter.
module shift_step
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_next
);

  // One-position shift selected by opcode; pass-through leaves the value alone.
  always_comb begin
    r_next = r;
    case (op)
      SH_SLL:  r_next = {r[WIDTH-2:0], 1'b0};
      SH_SRL:  r_next = {1'b0, r[WIDTH-1:1]};
      SH_SRA:  r_next = {r[WIDTH-1], r[WIDTH-1:1]};
      default: r_next = r;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative 1-bit-per-cycle shifter (SLL/SRL/SRA) for the execute stage.
// The registered result feeds the writeback mux; done selects it.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for start; result holds the last value
//  S_SHIFT | shifting one bit per cycle; cnt counts remaining bits down
//  S_DONE  | result valid for this one cycle; a new start may be accepted
module shift_unit_seq
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  state_t             state_q, state_n;
  logic [SHAMT_W-1:0] cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   step_r;

  logic load;      // capture data_in into the result register
  logic load_cnt;  // capture op/shamt for an iterative operation
  logic shift_en;  // advance the shift by one bit

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .r      (result_q),
    .r_next (step_r)
  );

  // Next-state and datapath enables; flush overrides everything below reset.
  always_comb begin
    state_n  = state_q;
    load     = 1'b0;
    load_cnt = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          load = 1'b1;
          if (needs_shift(op, shamt == '0)) begin
            load_cnt = 1'b1;
            state_n  = S_SHIFT;
          end else begin
            state_n  = S_DONE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == SHAMT_W'(1)) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n  = S_IDLE;
      load     = 1'b0;
      load_cnt = 1'b0;
      shift_en = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Remaining-bit down-counter and captured opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      op_q  <= SH_SLL;
    end else if (load_cnt) begin
      cnt_q <= shamt;
      op_q  <= op;
    end else if (shift_en) begin
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

  // Result register: loaded with the operand, then shifted in place.
  // It is deliberately not cleared on return to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           result_q <= '0;
    else if (load)     result_q <= data_in;
    else if (shift_en) result_q <= step_r;
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq.
// Inputs change and outputs are sampled on the falling clock edge.
// "Sample n" is the n-th falling edge after the edge that accepted start.
module tb_shift_unit_seq;
  import kgp_risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_total = 0;
  int n_pass  = 0;

  shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Drive a request for one edge; returns at sample 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    op = o; data_in = d; shamt = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the current sample, wait for done; lat is the sample index where done is seen.
  task automatic wait_done(input int first, output int lat, output int busy_n);
    lat = first; busy_n = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL reset_result got=%h exp=0", result); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done); else n_pass++;
  endtask

  task automatic test_sll();
    int lat, bn;
    issue(SH_SLL, 32'h0000_0001, 5'd4);
    wait_done(1, lat, bn);
    n_total++; if (lat != 5) $display("FAIL sll_latency got=%0d exp=5", lat); else n_pass++;
    n_total++; if (bn != 4) $display("FAIL sll_busy_cycles got=%0d exp=4", bn); else n_pass++;
    n_total++; if (result !== 32'h0000_0010) $display("FAIL sll_result got=%h exp=00000010", result); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL sll_done_pulse got=%b exp=0", done); else n_pass++;
    n_total++; if (result !== 32'h0000_0010) $display("FAIL sll_result_hold got=%h exp=00000010", result); else n_pass++;
    issue(SH_SLL, 32'h8000_0001, 5'd1);
    wait_done(1, lat, bn);
    n_total++; if (result !== 32'h0000_0002) $display("FAIL sll_discard got=%h exp=00000002", result); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_shift31();
    int lat, bn;
    issue(SH_SRA, 32'h8000_0000, 5'd31);
    wait_done(1, lat, bn);
    n_total++; if (lat != 32) $display("FAIL sra31_latency got=%0d exp=32", lat); else n_pass++;
    n_total++; if (result !== 32'hFFFF_FFFF) $display("FAIL sra31_result got=%h exp=ffffffff", result); else n_pass++;
    @(negedge clk);
    issue(SH_SRL, 32'h8000_0000, 5'd31);
    wait_done(1, lat, bn);
    n_total++; if (result !== 32'h0000_0001) $display("FAIL srl31_result got=%h exp=00000001", result); else n_pass++;
    @(negedge clk);
    issue(SH_SRA, 32'h4000_0000, 5'd3);
    wait_done(1, lat, bn);
    n_total++; if (result !== 32'h0800_0000) $display("FAIL sra_pos_result got=%h exp=08000000", result); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_pass();
    int lat, bn;
    issue(SH_SRL, 32'hDEAD_BEEF, 5'd0);
    wait_done(1, lat, bn);
    n_total++; if (lat != 1 || bn != 0) $display("FAIL zero_latency got=%0d/%0d exp=1/0", lat, bn); else n_pass++;
    n_total++; if (result !== 32'hDEAD_BEEF) $display("FAIL zero_result got=%h exp=deadbeef", result); else n_pass++;
    @(negedge clk);
    issue(SH_PASS, 32'hDEAD_BEEF, 5'd7);
    wait_done(1, lat, bn);
    n_total++; if (lat != 1 || bn != 0) $display("FAIL pass_latency got=%0d/%0d exp=1/0", lat, bn); else n_pass++;
    n_total++; if (result !== 32'hDEAD_BEEF) $display("FAIL pass_result got=%h exp=deadbeef", result); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    issue(SH_SLL, 32'h1, 5'd1);
    wait_done(1, lat, bn);
    n_total++; if (lat != 2) $display("FAIL b2b_first_latency got=%0d exp=2", lat); else n_pass++;
    n_total++; if (result !== 32'h2) $display("FAIL b2b_first_result got=%h exp=00000002", result); else n_pass++;
    issue(SH_SRL, 32'h8, 5'd2);
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept_in_done got=%b exp=1", busy); else n_pass++;
    wait_done(1, lat, bn);
    n_total++; if (lat != 3) $display("FAIL b2b_second_latency got=%0d exp=3", lat); else n_pass++;
    n_total++; if (result !== 32'h2) $display("FAIL b2b_second_result got=%h exp=00000002", result); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int ndone = 0;
    int first = -1;
    logic [31:0] res = '0;
    issue(SH_SLL, 32'h1, 5'd6);
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        ndone++;
        if (first < 0) begin first = i; res = result; end
      end
      if (i == 1 || i == 2) begin
        start = 1'b1; op = SH_PASS; data_in = 32'hFFFF_FFFF; shamt = 5'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    n_total++; if (ndone != 1) $display("FAIL ignore_done_count got=%0d exp=1", ndone); else n_pass++;
    n_total++; if (first != 7) $display("FAIL ignore_latency got=%0d exp=7", first); else n_pass++;
    n_total++; if (res !== 32'h0000_0040) $display("FAIL ignore_result got=%h exp=00000040", res); else n_pass++;
  endtask

  task automatic test_flush();
    int ndone = 0;
    int lat, bn;
    logic [31:0] held;
    issue(SH_SLL, 32'h1, 5'd10);
    repeat (4) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = SH_PASS; data_in = 32'h1234_5678; shamt = 5'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flush_to_idle busy=%b done=%b exp=0/0", busy, done); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    n_total++; if (ndone != 0) $display("FAIL flush_no_done got=%0d exp=0", ndone); else n_pass++;
    held = result;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || result !== held) $display("FAIL flush_idle_noop busy=%b done=%b result=%h exp=0/0/%h", busy, done, result, held); else n_pass++;
    issue(SH_SRL, 32'h0000_0100, 5'd4);
    wait_done(1, lat, bn);
    n_total++; if (lat != 5 || result !== 32'h0000_0010) $display("FAIL flush_restart lat=%0d result=%h exp=5/00000010", lat, result); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int ndone = 0;
    int nbusy = 0;
    issue(SH_SRA, 32'h8000_0000, 5'd8);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_mid_done got=%b exp=0", done); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL rst_mid_result got=%h exp=0", result); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      if (busy) nbusy++;
      @(negedge clk);
    end
    n_total++; if (ndone != 0 || nbusy != 0) $display("FAIL rst_mid_after done=%0d busy=%0d exp=0/0", ndone, nbusy); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sll();
    test_shift31();
    test_pass();
    test_back_to_back();
    test_ignore_busy();
    test_flush();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
